// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register selects, forwarding selects and scoreboard entries.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned FWD_W    = $clog2(SB_DEPTH + 1);

  typedef logic [FWD_W-1:0] fwdsel_t;

  localparam fwdsel_t FWD_RF = '0;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_if.sv
// Bundle of all non-clock hazard unit signals, with unit-side and bench-side views.
interface hazard_if
  import cpu_types_pkg::*;
();
  logic        nRST;
  logic        issue_valid;
  regbits_t    issue_wsel;
  logic        issue_load;
  regbits_t    rsel1;
  regbits_t    rsel2;
  logic        use1;
  logic        use2;
  logic        branch_taken;
  logic        mem_wait;
  logic        stall;
  logic        flush;
  fwdsel_t     fwd1;
  fwdsel_t     fwd2;
  logic        busy;
  logic [31:0] stall_cycles;

  modport hu (
    input  nRST, issue_valid, issue_wsel, issue_load, rsel1, rsel2, use1, use2,
           branch_taken, mem_wait,
    output stall, flush, fwd1, fwd2, busy, stall_cycles
  );

  modport tb (
    output nRST, issue_valid, issue_wsel, issue_load, rsel1, rsel2, use1, use2,
           branch_taken, mem_wait,
    input  stall, flush, fwd1, fwd2, busy, stall_cycles
  );
endinterface

// File: rtl/sb_match.sv
// Youngest-match priority encoder: finds the lowest stage whose in-flight write targets rsel.
module sb_match
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned FW   = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  regbits_t              rsel,
  input  logic                  src_used,
  output logic                  hit,
  output logic [FW-1:0]         stage,
  output logic                  is_load
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].wsel == rsel && rsel != '0 && src_used) begin
        hit     = 1'b1;
        stage   = FW'(i + 1);
        is_load = entries[i].load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based stall/flush/forwarding controller with a saturating stall counter.
// Define HAZARD_FORWARD_EN to enable operand forwarding; otherwise hazards stall until WB.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH    = SB_DEPTH,
  parameter int unsigned LOAD_LAT = 2,
  localparam int unsigned FW      = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          issue_valid,
  input  regbits_t      issue_wsel,
  input  logic          issue_load,
  input  regbits_t      rsel1,
  input  regbits_t      rsel2,
  input  logic          use1,
  input  logic          use2,
  input  logic          branch_taken,
  input  logic          mem_wait,
  output logic          stall,
  output logic          flush,
  output logic [FW-1:0] fwd1,
  output logic [FW-1:0] fwd2,
  output logic          busy,
  output logic [31:0]   stall_cycles
);

  // Index 0 models stage 1 (EX), index DEPTH-1 models WB.
  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t             new_ent;
  logic [31:0]           cnt_q;

  logic          hit1, hit2, load1, load2, haz1, haz2;
  logic [FW-1:0] stage1, stage2;

  sb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries  (sb_q),
    .rsel     (rsel1),
    .src_used (use1),
    .hit      (hit1),
    .stage    (stage1),
    .is_load  (load1)
  );

  sb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries  (sb_q),
    .rsel     (rsel2),
    .src_used (use2),
    .hit      (hit2),
    .stage    (stage2),
    .is_load  (load2)
  );

`ifdef HAZARD_FORWARD_EN
  assign haz1 = hit1 && load1 && (32'(stage1) <= LOAD_LAT);
  assign haz2 = hit2 && load2 && (32'(stage2) <= LOAD_LAT);
  assign fwd1 = (hit1 && !haz1) ? stage1 : FW'(FWD_RF);
  assign fwd2 = (hit2 && !haz2) ? stage2 : FW'(FWD_RF);
`else
  // WB writes the register file in the first half-cycle, so a WB-stage match is safe.
  assign haz1 = hit1 && (32'(stage1) < DEPTH);
  assign haz2 = hit2 && (32'(stage2) < DEPTH);
  assign fwd1 = '0;
  assign fwd2 = '0;
  logic unused_load;
  assign unused_load = load1 ^ load2 ^ LOAD_LAT[0];
`endif

  assign flush = branch_taken && !mem_wait;
  assign stall = (haz1 || haz2) && !flush;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | sb_q[i].valid;
    end
  end

  always_comb begin
    new_ent = '0;
    if (issue_valid && !stall && !flush) begin
      new_ent.valid = 1'b1;
      new_ent.wsel  = issue_wsel;
      new_ent.load  = issue_load;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else if (!mem_wait) begin
      sb_q <= {sb_q[DEPTH-2:0], new_ent};
      if (stall && cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = cnt_q;

endmodule
